ahbl_sram_slave: RTL and testbench

Parametrised AHB-Lite SRAM slave with configurable capacity and configurable wait states. Uses little-endian byte-lane writes and reads, with full 32-bit words. Returns a two-cycle ERROR response on unsupported or misaligned transfers. Sits behind the AHB-Lite bus decoder/mux as a generic on-chip memory target. Address decoding of HSEL is done externally.

---
 rtl/ahbl_pkg.sv | 48 ++++
 rtl/ahbl_sram_array.sv | 21 ++
 rtl/ahbl_sram_slave.sv | 104 ++++++++++
 tb/tb_ahbl_sram_slave.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and helpers for the SRAM slave.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

  // Latched data-phase request
  typedef struct packed {
    logic       vld;
    logic       write;
    logic [3:0] strb;
  } dphase_t;

  function automatic logic legal_f(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return !lane[0];
      HSIZE_WORD: return lane == 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] strb_f(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: return 4'b0001 << lane;
      HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahbl_sram_array.sv
// Word array with per-byte write enables; synchronous write, asynchronous read.
module ahbl_sram_array #(
  parameter int AW = 11
) (
  input  logic          HCLK,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [2**AW];

  always_ff @(posedge HCLK) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][i] <= wdata[8*i +: 8];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM target: byte-lane writes, configurable wait states, 2-cycle ERROR.
module ahbl_sram_slave
  import ahbl_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 13,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID          = 32'hABCD_EF00
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int         WA    = ADDR_WIDTH - 2;
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e          state;
  logic [3:0]      cnt;
  dphase_t         dp;
  logic [WA-1:0]   idx;
  logic [31:0]     rdata;
  logic            accept, legal, commit;
  logic            unused;

  assign unused = ^HADDR[31:ADDR_WIDTH];
  assign accept = HSEL & HREADY & HTRANS[1] & (state == ST_IDLE || state == ST_ERR2);
  assign legal  = legal_f(HSIZE, HADDR[1:0]);
  // IDLE with a live data phase is always the completing cycle
  assign commit = dp.vld & dp.write & (state == ST_IDLE);
  assign HRDATA = (dp.vld & ~dp.write) ? rdata : 32'h0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dp        <= '0;
      idx       <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
          dp.vld    <= accept & legal;
          if (accept) begin
            dp.write <= HWRITE;
            dp.strb  <= strb_f(HSIZE, HADDR[1:0]);
            idx      <= HADDR[ADDR_WIDTH-1:2];
            if (!legal) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= HRESP_ERROR;
            end else if (WAIT_STATES != 0) begin
              state     <= ST_WAIT;
              cnt       <= WS_M1;
              HREADYOUT <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  ahbl_sram_array #(.AW(WA)) u_array (
    .HCLK  (HCLK),
    .addr  (idx),
    .we    (dp.strb & {4{commit}}),
    .wdata (HWDATA),
    .rdata (rdata)
  );

`ifndef SYNTHESIS
  always_ff @(posedge HCLK) begin
    if (HRESETn && dp.vld && state == ST_IDLE)
      $display("[%08h] %s addr=%0h data=%08h", ID, dp.write ? "WR" : "RD",
               {idx, 2'b00}, dp.write ? HWDATA : rdata);
  end
`endif

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Randomized + directed bench for ahbl_sram_slave at WAIT_STATES 0, 2 and 3.
module tb_ahbl_sram_slave;

  localparam int NI = 3;
  localparam int WSV [NI] = '{0, 2, 3};
  localparam int MSZ = 8192;

  logic              HCLK = 0, HRESETn = 0;
  logic [NI-1:0]     hsel;
  logic [31:0]       HADDR, HWDATA;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [NI-1:0]     hro, hrsp;
  logic [NI-1:0][31:0] hrd;

  always #5 HCLK = ~HCLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ahbl_sram_slave #(.ADDR_WIDTH(13), .WAIT_STATES(WSV[g]), .ID(32'hABCD_EF00 + g)) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[g]), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(hro[g]), .HWDATA(HWDATA),
      .HREADYOUT(hro[g]), .HRESP(hrsp[g]), .HRDATA(hrd[g])
    );
  end

  int n_chk = 0, n_err = 0;

  // byte-addressed reference memory per instance
  logic [7:0] mem_m [NI][MSZ];
  bit         kn    [NI][MSZ];

  // outstanding data phase
  bit          pv = 0, pw, plegal;
  int          pk, pc;
  logic [12:0] pa;
  logic [2:0]  psz;
  logic [31:0] pwd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [12:0] a, input logic [2:0] sz);
    return (sz == 3'd0) || (sz == 3'd1 && a % 2 == 0) || (sz == 3'd2 && a % 4 == 0);
  endfunction

  function automatic bit word_m(input int k, input logic [12:0] a, output logic [31:0] w);
    int base = (a / 4) * 4;
    bit ok = 1;
    for (int b = 0; b < 4; b++) begin
      w[8*b +: 8] = mem_m[k][base + b];
      ok &= kn[k][base + b];
    end
    return ok;
  endfunction

  // One bus cycle, entered and left at a falling edge. Returns whether the
  // presented address phase was taken (previous data phase completing).
  task automatic cyc(input int k, input bit hs, input logic [1:0] tr, input bit wr,
                     input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                     output bit acc);
    bit cmpl = 1;
    logic [31:0] w;
    HWDATA = $urandom;
    if (pv) begin
      if (plegal) begin
        cmpl = (pc == WSV[pk]);
        chk("ok_rdy", hro[pk], cmpl);
        chk("ok_resp", hrsp[pk], 0);
        if (pw) chk("wr_rdata", hrd[pk], 0);
        else if (word_m(pk, pa, w)) chk("rd_data", hrd[pk], w);
      end else begin
        cmpl = (pc == 1);
        chk("err_rdy", hro[pk], cmpl);
        chk("err_resp", hrsp[pk], 1);
        chk("err_rdata", hrd[pk], 0);
      end
      if (cmpl) begin
        if (pw) HWDATA = pwd;
        if (pw && plegal)
          for (int b = 0; b < (1 << psz); b++) begin
            mem_m[pk][(pa + b) % MSZ] = pwd[8*((pa + b) % 4) +: 8];
            kn[pk][(pa + b) % MSZ] = 1;
          end
        pv = 0;
      end else pc++;
    end else begin
      chk("idle_rdy", hro[k], 1);
      chk("idle_resp", hrsp[k], 0);
      chk("idle_rdata", hrd[k], 0);
    end
    hsel = hs ? NI'(1) << k : '0;
    HTRANS = tr; HWRITE = wr; HADDR = a; HSIZE = sz;
    acc = cmpl;
    if (acc && hs && tr[1]) begin
      pv = 1; pk = k; pc = 0; pw = wr; pa = a[12:0]; psz = sz; pwd = wd;
      plegal = is_legal(a[12:0], sz);
    end
    @(negedge HCLK);
  endtask

  task automatic issue(input int k, input bit hs, input logic [1:0] tr, input bit wr,
                       input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    bit acc = 0;
    int guard = 0;
    while (!acc && guard < 64) begin
      cyc(k, hs, tr, wr, a, sz, wd, acc);
      guard++;
    end
    if (!acc) begin n_chk++; n_err++; $display("FAIL issue_timeout got=0 exp=1"); end
  endtask

  task automatic flush(input int k);
    int guard = 0;
    bit acc;
    while (pv && guard < 64) begin
      cyc(k, 0, 2'b00, 0, 0, 0, 0, acc);
      guard++;
    end
    cyc(k, 0, 2'b00, 0, 0, 0, 0, acc);
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    issue(k, 1, 2'b10, 1, a, sz, d);
  endtask

  task automatic rd(input int k, input logic [31:0] a, input logic [2:0] sz);
    issue(k, 1, 2'b10, 0, a, sz, 0);
  endtask

  initial begin
    bit acc;
    int k, last_k;
    hsel = '0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 0; HWDATA = 0;
    repeat (3) @(negedge HCLK);
    for (int i = 0; i < NI; i++) begin
      chk("rst_rdy", hro[i], 1);
      chk("rst_resp", hrsp[i], 0);
      chk("rst_rdata", hrd[i], 0);
    end
    HRESETn = 1;
    @(negedge HCLK);

    // back-to-back RAW, no stall
    wr(0, 32'h100, 3'd2, 32'hDEADBEEF);
    rd(0, 32'h100, 3'd2);
    flush(0);
    // byte lanes then halfword overlay
    wr(0, 32'h200, 3'd0, 32'h0000_0011);
    wr(0, 32'h201, 3'd0, 32'h0000_2200);
    wr(0, 32'h202, 3'd0, 32'h0033_0000);
    wr(0, 32'h203, 3'd0, 32'h4400_0000);
    rd(0, 32'h200, 3'd2);
    wr(0, 32'h202, 3'd1, 32'hAAAA_0000);
    rd(0, 32'h200, 3'd2);
    flush(0);
    chk("lanes_model", {mem_m[0][32'h203], mem_m[0][32'h202], mem_m[0][32'h201], mem_m[0][32'h200]},
        32'hAAAA2211);
    // misaligned word write and illegal size
    wr(0, 32'h04, 3'd2, 32'h0BAD_F00D);
    wr(0, 32'h06, 3'd2, 32'hFFFFFFFF);
    rd(0, 32'h04, 3'd2);
    rd(0, 32'h04, 3'd3);
    wr(0, 32'h09, 3'd1, 32'hFFFFFFFF);
    rd(0, 32'h08, 3'd0);
    flush(0);
    // wrap at 2**ADDR_WIDTH
    wr(0, 32'h0000_2004, 3'd2, 32'hCAFEF00D);
    rd(0, 32'h0000_0004, 3'd2);
    flush(0);
    // no-access cases must not touch memory
    issue(0, 0, 2'b10, 1, 32'h100, 3'd2, 32'h5555_5555);
    issue(0, 1, 2'b00, 1, 32'h100, 3'd2, 32'h6666_6666);
    issue(0, 1, 2'b01, 1, 32'h100, 3'd2, 32'h7777_7777);
    rd(0, 32'h100, 3'd2);
    flush(0);

    // wait states, HWDATA scrambled during wait cycles
    wr(1, 32'h10, 3'd2, 32'h12345678);
    rd(1, 32'h10, 3'd2);
    wr(1, 32'h16, 3'd2, 32'h0);
    rd(1, 32'h10, 3'd2);
    flush(1);

    // reset during 2nd wait cycle of a read
    wr(2, 32'h40, 3'd2, 32'hA5A5_1234);
    rd(2, 32'h40, 3'd2);
    cyc(2, 0, 2'b00, 0, 0, 0, 0, acc);
    chk("rstw_pre_rdy", hro[2], 0);
    HRESETn = 0;
    #1;
    chk("rstw_rdy", hro[2], 1);
    chk("rstw_resp", hrsp[2], 0);
    chk("rstw_rdata", hrd[2], 0);
    pv = 0;
    @(negedge HCLK);
    HRESETn = 1;
    @(negedge HCLK);
    rd(2, 32'h40, 3'd2);
    flush(2);

    // randomized traffic
    last_k = 2;
    for (int t = 0; t < 600; t++) begin
      logic [1:0]  tr;
      logic [2:0]  sz;
      logic [31:0] a;
      bit hs;
      k = $urandom_range(0, NI - 1);
      if (k != last_k) flush(last_k);
      last_k = k;
      tr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = {$urandom_range(0, 3) == 0 ? 19'($urandom) : 19'd0, 13'($urandom_range(0, 63))};
      hs = ($urandom_range(0, 9) != 0);
      issue(k, hs, tr, 1'($urandom), a, sz, $urandom);
    end
    flush(last_k);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
